// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared beat kinds, FSM states and widths for the register trace dumper
package trace_pkg;

  localparam logic [1:0] KIND_CYCLE = 2'd0;
  localparam logic [1:0] KIND_PC    = 2'd1;
  localparam logic [1:0] KIND_REG   = 2'd2;

  localparam int DROP_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    S_CYC = 2'd1,
    S_PC  = 2'd2,
    S_REG = 2'd3
  } state_t;

endpackage

// File: rtl/next_set_bit.sv
// rtl/next_set_bit.sv - lowest set mask index above cur (or from 0 when from_start), plus found flag
module next_set_bit #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic [NUM_REGS-1:0] mask,
  input  logic [ADDR_W-1:0]   cur,
  input  logic                from_start,
  output logic [ADDR_W-1:0]   nxt,
  output logic                found
);

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(cur)))) begin
        nxt   = ADDR_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_trace_dumper.sv
// rtl/reg_trace_dumper.sv - snapshots cycle count, PC and masked registers into a framed beat stream
module reg_trace_dumper
  import trace_pkg::*;
#(
  parameter int                      DATA_W   = 32,
  parameter int                      ADDR_W   = 5,
  parameter int                      NUM_REGS = 2 ** ADDR_W,
  parameter logic [NUM_REGS-1:0]     REG_MASK = 32'h00FF_0F00,
  parameter int                      CNT_W    = 16,
  parameter int                      PERIOD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              trig,
  input  logic [DATA_W-1:0] pc_in,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              hold_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam bit MASK_EMPTY = (REG_MASK == '0);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cyc_q;
  logic [DATA_W-1:0] pc_q;
  logic [ADDR_W-1:0] idx, idx_nxt, srch;
  logic              found;
  logic [31:0]       timer;
  logic              fire, trig_any, hs, accept;

  // In S_PC the search starts from index 0; in S_REG it finds the successor of idx.
  next_set_bit #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_next (
    .mask       (REG_MASK),
    .cur        (idx),
    .from_start (state != S_REG),
    .nxt        (srch),
    .found      (found)
  );

  assign hs       = out_valid && out_ready;
  assign fire     = (PERIOD > 0) && enable && (timer == 32'(PERIOD - 1));
  assign trig_any = trig || fire;
  assign accept   = trig_any && ((state == IDLE) || (hs && out_last));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      cyc_q    <= '0;
      pc_q     <= '0;
      timer    <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (enable) cnt <= cnt + 1'b1;
      if ((PERIOD > 0) && enable) timer <= fire ? 32'd0 : timer + 32'd1;
      if (accept) begin
        cyc_q <= cnt;
        pc_q  <= pc_in;
      end
      if (trig_any && !accept && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (accept) state_nxt = S_CYC;
      end
      S_CYC: begin
        if (hs) state_nxt = S_PC;
      end
      S_PC: begin
        if (hs) begin
          if (!MASK_EMPTY) begin
            state_nxt = S_REG;
            idx_nxt   = srch;
          end else begin
            state_nxt = accept ? S_CYC : IDLE;
            idx_nxt   = '0;
          end
        end
      end
      S_REG: begin
        if (hs) begin
          if (found) begin
            idx_nxt = srch;
          end else begin
            state_nxt = accept ? S_CYC : IDLE;
            idx_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // All beat fields derive from registered state, so they hold while the sink stalls.
  always_comb begin
    out_valid  = 1'b0;
    hold_req   = 1'b0;
    out_kind   = KIND_CYCLE;
    out_addr   = '0;
    out_data   = '0;
    out_last   = 1'b0;
    rf_rd_addr = '0;
    case (state)
      S_CYC: begin
        out_valid = 1'b1;
        hold_req  = 1'b1;
        out_kind  = KIND_CYCLE;
        out_data  = DATA_W'(cyc_q);
      end
      S_PC: begin
        out_valid = 1'b1;
        hold_req  = 1'b1;
        out_kind  = KIND_PC;
        out_data  = pc_q;
        out_last  = MASK_EMPTY;
      end
      S_REG: begin
        out_valid  = 1'b1;
        hold_req   = 1'b1;
        out_kind   = KIND_REG;
        out_addr   = idx;
        rf_rd_addr = idx;
        out_data   = rf_rd_data;
        out_last   = !found;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

endmodule
